rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Arbitrates the single register-file write port between the pipeline writeback stage and a multi-cycle multiply/divide unit. It buffers one completed mul/div result and drains it into idle writeback slots. If the writeback stage keeps the port busy, it inserts a one-cycle pipeline stall to force the drain. The block sits between the writeback stage and the `rf_writeback_*` inputs of the decode cycle, and exposes the buffered destination to hazard control.

## Interface
- `XLEN`, 32, data width
- `REGISTER_SIZE`, 5, register address width
- `STARVE_LIMIT`, 4, consecutive cycles a buffered result may lose arbitration before a forced drain (≥1); counter width `$clog2(STARVE_LIMIT+1)`

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `wb_write_enable` in 1: writeback stage write request.
- `wb_write_addr` in `REGISTER_SIZE`: writeback destination.
- `wb_write_data` in `XLEN`: writeback data.
- `md_valid` in 1: mul/div result valid.
- `md_ready` out 1: arbiter can accept the mul/div result.
- `md_addr` in `REGISTER_SIZE`: mul/div destination.
- `md_data` in `XLEN`: mul/div result.
- `rf_writeback_enable` out 1: register-file write enable.
- `rf_writeback_addr` out `REGISTER_SIZE`: register-file write address.
- `rf_writeback_data` out `XLEN`: register-file write data.
- `wb_stall` out 1: registered; freezes the pipeline (writeback stage re-presents the same request next cycle).
- `pending_valid` out 1: buffer holds an unwritten result.
- `pending_addr` out `REGISTER_SIZE`: destination of the buffered result (0 when empty).

## Operation
- Effective wb request: `wbr = wb_write_enable && wb_write_addr != 0`. A wb write to x0 never reaches the port.
- An md transfer happens when `md_valid && md_ready`. An md result with `md_addr == 0` is accepted and discarded.
- States:
  - IDLE: buffer empty.
  - HELD: buffer full.
  - FORCE: stall cycle, buffer draining.
- IDLE: `md_ready=1`.
  - `wbr`: port is given to wb. Any md transfer is captured into the buffer, and the state goes to HELD with counter=0.
  - `!wbr` with an md transfer: the md result is written directly this cycle (bypass) and the state stays IDLE.
- HELD: `md_ready=0`, `pending_valid=1`.
  - `!wbr`: port is given to the buffer, which clears; go to IDLE.
  - `wbr` with `wb_write_addr == pending_addr`: wb writes, the buffer is dropped as stale, go to IDLE.
  - `wbr`, other address: wb writes and the counter increments. When the counter reaches `STARVE_LIMIT`, `wb_stall` is set for the next cycle and the state goes to FORCE.
- FORCE: `wb_stall=1`, `md_ready=0`. The buffer is granted the port regardless of `wbr`; the wb request is ignored (it is re-presented next cycle). The buffer clears and the state goes to IDLE with counter=0.
- Same-cycle same-address collision in IDLE (wb write plus md capture to the same rd): md is stored and written later. The md result is program-order newer than the concurrent wb write.
- Port mux is combinational: the granted source drives addr/data. When nothing is granted, enable=0, addr=0, data=0.

## Timing
- Reset (while `rst` is high and on the first cycle after): state IDLE, buffer empty, counter=0.
  - Outputs during reset: `wb_stall=0`, `pending_valid=0`, `pending_addr=0`, `md_ready=0`, `rf_writeback_enable=0`.
  - `md_ready` rises in the first cycle with `rst` low.
- Reset mid-operation discards the buffered result; no write is issued for it.
- Latency:
  - wb write: 0 cycles (same cycle), except during the FORCE cycle.
  - md bypass: 0 cycles.
  - Buffered md: written no later than `STARVE_LIMIT+1` cycles after capture.
- `wb_stall` is high for exactly one cycle per forced drain and never in consecutive cycles.
- `md_ready` depends only on state and `rst`, never combinationally on `md_valid`.
- At most one register-file write per cycle; `rf_writeback_enable` never asserts with address 0.

## Test plan
- Reset: hold `rst` 3 cycles with `wb_write_enable=1`, `md_valid=1` -> `rf_writeback_enable=0`, `md_ready=0`, `wb_stall=0` throughout; `md_ready=1` in the first cycle after release.
- Bypass: wb idle, md result (x5, 0x1234) -> same cycle `rf_writeback_enable=1`, addr 5, data 0x1234; `pending_valid` stays 0.
- Buffer and drain: wb writes x3 while md delivers (x7, 0xAA).
  - Next cycle `pending_valid=1`, `pending_addr=7`, `md_ready=0`.
  - In the first cycle wb is idle, x7=0xAA is written, then IDLE.
- Starvation: `STARVE_LIMIT=4`, buffered x9, wb writing x1..x6 continuously.
  - After 4 wb wins, `wb_stall=1` for one cycle and x9 is written in that cycle.
  - The wb request presented in that cycle is written in the following cycle.
- Stale drop: buffered (x4, 0x11), then wb writes (x4, 0x22) -> the port writes 0x22, `pending_valid` falls, and x4 is never written with 0x11.
- x0 handling:
  - wb write to x0 while buffer holds x2 -> x2 drains that cycle.
  - md result to x0 -> accepted, no write, `pending_valid=0`.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write port arbiter between writeback and mul/div
// Buffers one mul/div result and drains it into idle writeback slots, forcing a stall on starvation.
module rf_write_arbiter #(
    parameter int XLEN          = 32,
    parameter int REGISTER_SIZE = 5,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_write_enable,
    input  logic [REGISTER_SIZE-1:0] wb_write_addr,
    input  logic [XLEN-1:0]          wb_write_data,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [REGISTER_SIZE-1:0] md_addr,
    input  logic [XLEN-1:0]          md_data,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    output logic                     wb_stall,
    output logic                     pending_valid,
    output logic [REGISTER_SIZE-1:0] pending_addr
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HELD  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
    logic [REGISTER_SIZE-1:0] buf_addr_q, buf_addr_d;
    logic [XLEN-1:0]          buf_data_q, buf_data_d;
    logic                     wb_stall_q, wb_stall_d;
    logic                     wbr, md_xfer, md_live;
    logic                     grant_wb, grant_buf, grant_md;

    assign wbr      = wb_write_enable && (wb_write_addr != '0);
    assign md_ready = !rst && (state_q == S_IDLE);
    assign md_xfer  = md_valid && md_ready;
    // Results targeting x0 are accepted but never stored or written.
    assign md_live  = md_xfer && (md_addr != '0);
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wb_stall_d = 1'b0;
        grant_wb   = 1'b0;
        grant_buf  = 1'b0;
        grant_md   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wbr) begin
                    grant_wb = 1'b1;
                    if (md_live) begin
                        buf_addr_d = md_addr;
                        buf_data_d = md_data;
                        cnt_d      = '0;
                        state_d    = S_HELD;
                    end
                end else if (md_live) begin
                    grant_md = 1'b1;
                end
            end
            S_HELD: begin
                if (!wbr) begin
                    grant_buf = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    grant_wb = 1'b1;
                    if (wb_write_addr == buf_addr_q) begin
                        // The newer wb write supersedes the buffered value.
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(STARVE_LIMIT)) begin
                            wb_stall_d = 1'b1;
                            state_d    = S_FORCE;
                        end
                    end
                end
            end
            S_FORCE: begin
                grant_buf = 1'b1;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            wb_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            wb_stall_q <= wb_stall_d;
        end
    end

    always_comb begin
        rf_writeback_enable = 1'b0;
        rf_writeback_addr   = '0;
        rf_writeback_data   = '0;
        if (!rst) begin
            if (grant_buf) begin
                rf_writeback_enable = 1'b1;
                rf_writeback_addr   = buf_addr_q;
                rf_writeback_data   = buf_data_q;
            end else if (grant_wb) begin
                rf_writeback_enable = 1'b1;
                rf_writeback_addr   = wb_write_addr;
                rf_writeback_data   = wb_write_data;
            end else if (grant_md) begin
                rf_writeback_enable = 1'b1;
                rf_writeback_addr   = md_addr;
                rf_writeback_data   = md_data;
            end
        end
    end

    assign wb_stall      = wb_stall_q && !rst;
    assign pending_valid = !rst && (state_q == S_HELD || state_q == S_FORCE);
    assign pending_addr  = pending_valid ? buf_addr_q : '0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_writeback_enable;
    logic [4:0]  rf_writeback_addr;
    logic [31:0] rf_writeback_data;
    logic        wb_stall;
    logic        pending_valid;
    logic [4:0]  pending_addr;

    int n_cmp = 0;
    int n_bad = 0;

    rf_write_arbiter #(.XLEN(32), .REGISTER_SIZE(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .rf_writeback_enable(rf_writeback_enable), .rf_writeback_addr(rf_writeback_addr),
        .rf_writeback_data(rf_writeback_data), .wb_stall(wb_stall),
        .pending_valid(pending_valid), .pending_addr(pending_addr)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
    task automatic set_in(input logic r, input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                          input logic mdv, input logic [4:0] mda, input logic [31:0] mdd);
        @(negedge clk);
        rst = r;
        wb_write_enable = wbe; wb_write_addr = wba; wb_write_data = wbd;
        md_valid = mdv; md_addr = mda; md_data = mdd;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd5, 32'h5);
            n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL rst_en got %0b want 0", rf_writeback_enable); end
            n_cmp++; if (md_ready !== 1'b0) begin n_bad++; $display("FAIL rst_md_ready got %0b want 0", md_ready); end
            n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %0b want 0", wb_stall); end
            n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pv got %0b want 0", pending_valid); end
        end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (md_ready !== 1'b1) begin n_bad++; $display("FAIL rel_md_ready got %0b want 1", md_ready); end
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL rel_en got %0b want 0", rf_writeback_enable); end
        n_cmp++; if (pending_addr !== 5'd0) begin n_bad++; $display("FAIL rel_pa got %0d want 0", pending_addr); end
    endtask

    task automatic test_bypass();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        n_cmp++; if (rf_writeback_enable !== 1'b1) begin n_bad++; $display("FAIL byp_en got %0b want 1", rf_writeback_enable); end
        n_cmp++; if (rf_writeback_addr !== 5'd5) begin n_bad++; $display("FAIL byp_addr got %0d want 5", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'h1234) begin n_bad++; $display("FAIL byp_data got %h want 1234", rf_writeback_data); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL byp_pv got %0b want 0", pending_valid); end
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL byp_idle_en got %0b want 0", rf_writeback_enable); end
    endtask

    task automatic test_buffer_drain();
        set_in(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hAA);
        n_cmp++; if (rf_writeback_addr !== 5'd3) begin n_bad++; $display("FAIL buf_wb_addr got %0d want 3", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'h33) begin n_bad++; $display("FAIL buf_wb_data got %h want 33", rf_writeback_data); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (pending_valid !== 1'b1) begin n_bad++; $display("FAIL buf_pv got %0b want 1", pending_valid); end
        n_cmp++; if (pending_addr !== 5'd7) begin n_bad++; $display("FAIL buf_pa got %0d want 7", pending_addr); end
        n_cmp++; if (md_ready !== 1'b0) begin n_bad++; $display("FAIL buf_md_ready got %0b want 0", md_ready); end
        n_cmp++; if (rf_writeback_addr !== 5'd7) begin n_bad++; $display("FAIL drain_addr got %0d want 7", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'hAA) begin n_bad++; $display("FAIL drain_data got %h want aa", rf_writeback_data); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL drain_pv got %0b want 0", pending_valid); end
        n_cmp++; if (md_ready !== 1'b1) begin n_bad++; $display("FAIL drain_md_ready got %0b want 1", md_ready); end
    endtask

    task automatic test_starvation();
        set_in(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h99);
        n_cmp++; if (rf_writeback_addr !== 5'd1) begin n_bad++; $display("FAIL stv_cap_addr got %0d want 1", rf_writeback_addr); end
        for (int i = 2; i <= 5; i++) begin
            set_in(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0);
            n_cmp++; if (rf_writeback_addr !== 5'(i)) begin n_bad++; $display("FAIL stv_wb_addr got %0d want %0d", rf_writeback_addr, i); end
            n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL stv_early_stall got %0b want 0 at x%0d", wb_stall, i); end
            n_cmp++; if (pending_valid !== 1'b1) begin n_bad++; $display("FAIL stv_pv got %0b want 1 at x%0d", pending_valid, i); end
        end
        set_in(1'b0, 1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL stv_stall got %0b want 1", wb_stall); end
        n_cmp++; if (rf_writeback_addr !== 5'd9) begin n_bad++; $display("FAIL stv_force_addr got %0d want 9", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'h99) begin n_bad++; $display("FAIL stv_force_data got %h want 99", rf_writeback_data); end
        n_cmp++; if (md_ready !== 1'b0) begin n_bad++; $display("FAIL stv_md_ready got %0b want 0", md_ready); end
        set_in(1'b0, 1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL stv_stall_after got %0b want 0", wb_stall); end
        n_cmp++; if (rf_writeback_addr !== 5'd6) begin n_bad++; $display("FAIL stv_replay_addr got %0d want 6", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'h106) begin n_bad++; $display("FAIL stv_replay_data got %h want 106", rf_writeback_data); end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL stv_pv_after got %0b want 0", pending_valid); end
    endtask

    task automatic test_stale_drop();
        set_in(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h11);
        set_in(1'b0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (rf_writeback_data !== 32'h22) begin n_bad++; $display("FAIL stale_data got %h want 22", rf_writeback_data); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL stale_pv got %0b want 0", pending_valid); end
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL stale_en got %0b want 0", rf_writeback_enable); end
    endtask

    task automatic test_x0();
        set_in(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2222);
        set_in(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (rf_writeback_addr !== 5'd2) begin n_bad++; $display("FAIL x0_drain_addr got %0d want 2", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'h2222) begin n_bad++; $display("FAIL x0_drain_data got %h want 2222", rf_writeback_data); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        n_cmp++; if (md_ready !== 1'b1) begin n_bad++; $display("FAIL x0_md_ready got %0b want 1", md_ready); end
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL x0_md_en got %0b want 0", rf_writeback_enable); end
        set_in(1'b0, 1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL x0_pv got %0b want 0", pending_valid); end
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL x0_wb_en got %0b want 0", rf_writeback_enable); end
    endtask

    task automatic test_collision();
        set_in(1'b0, 1'b1, 5'd3, 32'hA0, 1'b1, 5'd3, 32'hB0);
        n_cmp++; if (rf_writeback_data !== 32'hA0) begin n_bad++; $display("FAIL col_wb_data got %h want a0", rf_writeback_data); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (rf_writeback_addr !== 5'd3) begin n_bad++; $display("FAIL col_md_addr got %0d want 3", rf_writeback_addr); end
        n_cmp++; if (rf_writeback_data !== 32'hB0) begin n_bad++; $display("FAIL col_md_data got %h want b0", rf_writeback_data); end
    endtask

    task automatic test_mid_reset();
        set_in(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hC0);
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL mrst_en got %0b want 0", rf_writeback_enable); end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_pv got %0b want 0", pending_valid); end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_cmp++; if (rf_writeback_enable !== 1'b0) begin n_bad++; $display("FAIL mrst_rel_en got %0b want 0", rf_writeback_enable); end
        n_cmp++; if (pending_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_rel_pv got %0b want 0", pending_valid); end
        n_cmp++; if (md_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_md_ready got %0b want 1", md_ready); end
    endtask

    initial begin
        rst = 1'b1;
        wb_write_enable = 1'b0; wb_write_addr = '0; wb_write_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        test_reset();
        test_bypass();
        test_buffer_drain();
        test_starvation();
        test_stale_drop();
        test_x0();
        test_collision();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
